// File: rtl/bilateral_pkg.sv
// Shared constants, helpers and state encoding for the bilateral-filter scan controller.
// Defaults describe a 256x256 image with an 11x11 window (radius 5).
// The helpers derive window size and interior-pixel count from any geometry.
package bilateral_pkg;

    localparam int DEF_IMG_W  = 256;
    localparam int DEF_IMG_H  = 256;
    localparam int DEF_RADIUS = 5;
    localparam int DEF_ADDR_W = 16;

    function automatic int win_size(input int radius);
        return 2 * radius + 1;
    endfunction

    function automatic int out_count(input int w, input int h, input int radius);
        return (w - 2 * radius) * (h - 2 * radius);
    endfunction

    localparam int WIN       = win_size(DEF_RADIUS);
    localparam int OUT_COUNT = out_count(DEF_IMG_W, DEF_IMG_H, DEF_RADIUS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/bilateral_addr_gen.sv
// Fetch address generator: walks y (outer), x, k (inner, window row) and forms {row, x}.
// Latency: address and flags are combinational from the counter registers.
// Backpressure: counters advance only when adv is high; otherwise the address holds.
// Ports: clear forces start values, adv counts one fetch, addr/last_fetch/col_first/win_full
// describe the fetch currently presented.
module bilateral_addr_gen
    import bilateral_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int RADIUS = DEF_RADIUS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last_fetch,
    output logic              col_first,
    output logic              win_full
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = ADDR_W - XW;
    localparam int KW = $clog2(win_size(RADIUS));

    localparam logic [YW-1:0] Y_FIRST = YW'(RADIUS);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1 - RADIUS);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_FULL  = XW'(2 * RADIUS);
    localparam logic [KW-1:0] K_LAST  = KW'(2 * RADIUS);

    logic [YW-1:0] y_q;
    logic [XW-1:0] x_q;
    logic [KW-1:0] k_q;
    logic [YW-1:0] row;

    // Window row k of output row y sits at image row y-RADIUS+k.
    assign row        = y_q - Y_FIRST + YW'(k_q);
    assign addr       = {row, x_q};
    assign last_fetch = (y_q == Y_LAST) && (x_q == X_LAST) && (k_q == K_LAST);
    assign col_first  = (k_q == '0);
    assign win_full   = (x_q >= X_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= Y_FIRST;
            x_q <= '0;
            k_q <= '0;
        end else if (clear || (adv && last_fetch)) begin
            y_q <= Y_FIRST;
            x_q <= '0;
            k_q <= '0;
        end else if (adv) begin
            if (k_q == K_LAST) begin
                k_q <= '0;
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

endmodule

// File: rtl/bilateral_scan_ctrl.sv
// Scan controller: fetches window columns, forwards pixels to the core, maps results to addresses.
// Latency: pixel flags 1 cycle after in_addr; out_* 1 cycle after res_valid; finish 1 cycle after last out_valid.
// Backpressure: core_ready=0 freezes in_addr and fetch counting; an already issued fetch is still delivered.
// Ports: in_addr/in_data memory side, pix_* to core, res_* from core, out_* result write, finish.
// Optional macro STALL_CNT_EN adds stall_cnt, a saturating count of FETCH cycles with core_ready=0.
module bilateral_scan_ctrl
    import bilateral_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int RADIUS = DEF_RADIUS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic              col_first,
    output logic              win_full,
    input  logic              core_ready,
    input  logic              res_valid,
    input  logic [7:0]        res_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
`ifdef STALL_CNT_EN
    output logic [19:0]       stall_cnt,
`endif
    output logic              finish
);

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = ADDR_W - XW;
    localparam int OUT_N = out_count(IMG_W, IMG_H, RADIUS);
    localparam int CW    = $clog2(OUT_N + 1);

    localparam logic [CW-1:0] OUT_MAX  = CW'(OUT_N);
    localparam logic [XW-1:0] OX_FIRST = XW'(RADIUS);
    localparam logic [XW-1:0] OX_LAST  = XW'(IMG_W - 1 - RADIUS);
    localparam logic [YW-1:0] OY_FIRST = YW'(RADIUS);

    scan_state_t       state_q, state_d;
    logic              fetch_act, adv, accept;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last, gen_col_first, gen_win_full;
    logic [XW-1:0]     ox_q;
    logic [YW-1:0]     oy_q;
    logic [CW-1:0]     res_cnt_q;

    assign fetch_act = (state_q == FETCH);
    assign adv       = fetch_act && core_ready;
    // Results are only meaningful while a frame is in flight; surplus ones are dropped.
    assign accept    = res_valid && (state_q == FETCH || state_q == DRAIN) && (res_cnt_q != OUT_MAX);

    bilateral_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .RADIUS (RADIUS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == IDLE),
        .adv        (adv),
        .addr       (gen_addr),
        .last_fetch (gen_last),
        .col_first  (gen_col_first),
        .win_full   (gen_win_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = FETCH;
            FETCH:   if (adv && gen_last) state_d = DRAIN;
            DRAIN:   if (res_cnt_q == OUT_MAX) state_d = DONE;
            DONE:    if (!in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_addr  = fetch_act ? gen_addr : '0;
    assign finish   = (state_q == DONE);
    // Memory returns data one cycle after the address, aligned with the registered flags.
    assign pix_data = pix_valid ? in_data : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            col_first <= 1'b0;
            win_full  <= 1'b0;
        end else begin
            pix_valid <= adv;
            col_first <= adv && gen_col_first;
            win_full  <= adv && gen_win_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= 8'd0;
            ox_q      <= OX_FIRST;
            oy_q      <= OY_FIRST;
            res_cnt_q <= '0;
        end else begin
            out_valid <= accept;
            out_addr  <= accept ? {oy_q, ox_q} : '0;
            out_data  <= accept ? res_data : 8'd0;
            if (state_q == IDLE) begin
                ox_q      <= OX_FIRST;
                oy_q      <= OY_FIRST;
                res_cnt_q <= '0;
            end else if (accept) begin
                res_cnt_q <= res_cnt_q + CW'(1);
                if (ox_q == OX_LAST) begin
                    ox_q <= OX_FIRST;
                    oy_q <= oy_q + YW'(1);
                end else begin
                    ox_q <= ox_q + XW'(1);
                end
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [19:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            stall_q <= '0;
        end else if (fetch_act && !core_ready && stall_q != '1) begin
            stall_q <= stall_q + 20'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/bilateral_scan_ctrl.md
# bilateral_scan_ctrl

Sequencing controller for the 256x256 bilateral-filter datapath. It scans the image column-strip by column-strip, issues pixel fetch addresses to the external image memory, forwards returned pixels to the filter core with window-framing flags, and maps core results onto output addresses. It raises `finish` once every interior pixel has been written. It sits between the testbench/memory port (`in_addr`/`in_data`, `out_addr`/`out_data`) and the arithmetic filter core.

## Interface
- `IMG_W`, 256: image width in pixels; must be a power of two.
- `IMG_H`, 256: image height in pixels.
- `RADIUS`, 5: window radius; the window is (2*RADIUS+1) square.
- `ADDR_W`, 16: address width; equals log2(IMG_W*IMG_H).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: image memory available; a rising level starts a frame.
- `in_addr`  out  ADDR_W: pixel fetch address; data returns one cycle later.
- `in_data`  in  8: pixel at the previous cycle's `in_addr`.
- `pix_valid`  out  1: `pix_data` is valid for the core.
- `pix_data`  out  8: forwarded pixel.
- `col_first`  out  1: with `pix_valid`, marks the first pixel (top row) of a column.
- `win_full`  out  1: with `pix_valid`, marks a column that completes a full window (x >= 2*RADIUS).
- `core_ready`  in  1: core can accept a pixel fetched this cycle.
- `res_valid`  in  1: core result valid. Results arrive in order, one per full window.
- `res_data`  in  8: core result.
- `out_valid`  out  1: `out_data` is valid for `out_addr`.
- `out_addr`  out  ADDR_W: output pixel address.
- `out_data`  out  8: filtered pixel.
- `finish`  out  1: frame complete.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: all outputs are 0. Moves to FETCH on `in_valid`=1.
- FETCH:
  - Counters: y runs RADIUS..IMG_H-1-RADIUS (outer), x runs 0..IMG_W-1, k runs 0..2*RADIUS (inner).
  - `in_addr` = (y-RADIUS+k)*IMG_W + x, formed by concatenation {row, x}.
  - Counters advance only in cycles with `core_ready`=1. With `core_ready`=0, `in_addr` holds and no fetch is counted.
  - After the last fetch (y=IMG_H-1-RADIUS, x=IMG_W-1, k=2*RADIUS), moves to DRAIN.
- Pixel forwarding: `pix_valid`, `col_first` and `win_full` are the registered fetch-issue flags, one cycle behind `in_addr`. `pix_data` = `in_data` combinationally.
  - `col_first` = (k==0).
  - `win_full` = (x >= 2*RADIUS).
- Output counters: row oy starts at RADIUS and column ox starts at RADIUS. They advance on each `res_valid`. ox wraps IMG_W-1-RADIUS -> RADIUS and increments oy.
  - `out_addr` = oy*IMG_W + ox.
  - `out_data` = `res_data`.
  - All three are registered, so output latency is 1 cycle from `res_valid`.
- DRAIN: waits until the result count reaches (IMG_W-2*RADIUS)*(IMG_H-2*RADIUS), which is 60516 at the defaults, then moves to DONE.
- DONE: `finish`=1 is held. Returns to IDLE when `in_valid`=0.
- `res_valid` in IDLE or DONE is ignored and does not advance the output counters.
- A result arriving after the count has reached its maximum is dropped.
- `in_valid` falling during FETCH or DRAIN has no effect. The frame completes.

## Timing
- Reset: state=IDLE, all counters at their start values, and every output is 0.
- Reset mid-frame aborts immediately, with no partial `finish`.
- First `in_addr` is presented in the first cycle of FETCH: address 0 (y=5, x=0, k=0).
- Fetch rate is 1 per cycle when `core_ready`=1. Fetches per frame = (2*RADIUS+1)*IMG_W*(IMG_H-2*RADIUS) = 692736.
- Stall rule: a fetch issued with `core_ready`=1 is always delivered as `pix_valid` on the next cycle, even if `core_ready` has dropped by then.
- `finish` rises the cycle after the last `out_valid`.
- `out_valid` and `finish` are never high in the same cycle.

## Configuration
- `STALL_CNT_EN` defined: adds output `stall_cnt` (20 bits).
  - Counts FETCH cycles with `core_ready`=0 and saturates at all-ones.
  - Cleared on reset and on the IDLE->FETCH transition.
- `STALL_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `bilateral_pkg` holds:
  - IMG_W, IMG_H, RADIUS, ADDR_W defaults;
  - WIN = 2*RADIUS+1;
  - OUT_COUNT = (IMG_W-2*RADIUS)*(IMG_H-2*RADIUS);
  - the state enum `scan_state_t`.
- Sub-module `bilateral_addr_gen` holds the y/x/k fetch counters, address formation, and `last_fetch`/`col_first`/`win_full` generation.
- The top level holds the FSM, the pixel forwarding register, the output counters and the optional stall counter.

## Test plan
- Reset check: assert `rst_n`=0 mid-FETCH -> all outputs are 0 asynchronously. After release, the block is in IDLE and `out_valid`=0.
- Fetch order: `core_ready`=1, pulse `in_valid`.
  - The first 12 `in_addr` values are 0,256,...,2560,1.
  - `pix_valid` lags by 1 cycle.
  - `col_first` is high on pixels 0 and 11.
  - `win_full` first rises at x=10 (address 10).
- Stall: drop `core_ready` for 3 cycles mid-column -> `in_addr` is frozen, exactly one in-flight `pix_valid` is delivered, and no address is skipped or duplicated.
- Output mapping: drive `res_valid` with `res_data`=count mod 256.
  - First `out_addr` = 0x0505.
  - The 247th result lands at 0x0605.
  - The last lands at 0xFAFA.
- Completion: the full frame with a 1-cycle core echo gives exactly 60516 `out_valid` pulses. `finish` rises the following cycle and falls after `in_valid`=0 and the return to IDLE.
- `STALL_CNT_EN` build: random `core_ready` with 25% low -> `stall_cnt` equals the bench-counted low cycles during FETCH.
